// File: rtl/cp0_if.sv
// Pipeline <-> CP0 signal bundle: mfc0/mtc0 register port, commit-stage
// exception info, device interrupt lines and the request/return-address outputs.
interface cp0_if;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] din;
  logic        WE;
  logic [31:0] pc;
  logic        BD;
  logic [4:0]  exccode;
  logic        EXLClr;
  logic [7:2]  HWInt;
  logic        Req;
  logic [31:0] EPC;
  logic [31:0] dataOut;

  modport slave (
    input  A1, A2, din, WE, pc, BD, exccode, EXLClr, HWInt,
    output Req, EPC, dataOut
  );

  modport master (
    output A1, A2, din, WE, pc, BD, exccode, EXLClr, HWInt,
    input  Req, EPC, dataOut
  );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PRId, interrupt and exception arbitration,
// and the eret return address for the pipelined MIPS core.
module cp0 #(
  parameter logic [31:0] PRID = 32'h0000_4C43
) (
  input logic  clk,
  input logic  reset,
  cp0_if.slave bus
);

  typedef enum logic {NORMAL, HANDLER} exlState_t;

  exlState_t   r_state;
  exlState_t   w_stateNext;
  logic [5:0]  r_im;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_excCode;
  logic [31:0] r_epc;

  logic        w_exl;
  logic        w_intReq;
  logic        w_excReq;
  logic        w_req;
  logic        w_writeSr;
  logic        w_writeEpc;
  logic [31:0] w_pcAligned;
  logic [31:0] w_sr;
  logic [31:0] w_cause;
  logic        w_unused;

  assign w_exl       = (r_state == HANDLER);
  assign w_intReq    = (|(bus.HWInt & r_im)) & r_ie & ~w_exl;
  assign w_excReq    = (bus.exccode != 5'd0) & ~w_exl;
  assign w_req       = w_intReq | w_excReq;
  assign w_writeSr   = bus.WE & ~w_req & (bus.A2 == 5'd12);
  assign w_writeEpc  = bus.WE & ~w_req & (bus.A2 == 5'd14);
  assign w_pcAligned = {bus.pc[31:2], 2'b00};

  // The EXL bit is the handler state; EXLClr overrides an mtc0 write of EXL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= NORMAL;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_req) begin
      w_stateNext = HANDLER;
    end else begin
      if (w_writeSr) begin
        w_stateNext = bus.din[1] ? HANDLER : NORMAL;
      end
      if (bus.EXLClr) begin
        w_stateNext = NORMAL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im      <= 6'd0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip      <= 6'd0;
      r_excCode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip <= bus.HWInt;
      if (w_req) begin
        r_bd      <= bus.BD;
        r_excCode <= w_intReq ? 5'd0 : bus.exccode;
        r_epc     <= bus.BD ? (w_pcAligned - 32'd4) : w_pcAligned;
      end else begin
        if (w_writeSr) begin
          r_im <= bus.din[15:10];
          r_ie <= bus.din[0];
        end
        if (w_writeEpc) begin
          r_epc <= bus.din;
        end
      end
    end
  end

  assign w_sr    = {16'd0, r_im, 8'd0, w_exl, r_ie};
  assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_excCode, 2'b00};

  always_comb begin
    bus.dataOut = 32'd0;
    case (bus.A1)
      5'd12:   bus.dataOut = w_sr;
      5'd13:   bus.dataOut = w_cause;
      5'd14:   bus.dataOut = r_epc;
      5'd15:   bus.dataOut = PRID;
      default: bus.dataOut = 32'd0;
    endcase
  end

  assign bus.Req = w_req;
  assign bus.EPC = r_epc;

  // Write-data and PC bits that have no home in any register.
  assign w_unused = ^{bus.din[31:16], bus.din[9:2], bus.pc[1:0]};

endmodule
